// File: rtl/dcache_pkg.sv
// Shared field widths, line layout and FSM encoding for the data cache controller.
package dcache_pkg;

    localparam int ADDR_W   = 23;
    localparam int WORD_W   = 16;
    localparam int TAG_W    = 16;
    localparam int INDEX_W  = 5;
    localparam int OFFSET_W = 2;
    localparam int WORDS    = 4;
    localparam int LINE_W   = 82;

    typedef logic [TAG_W-1:0]    tag_t;
    typedef logic [INDEX_W-1:0]  index_t;
    typedef logic [OFFSET_W-1:0] offset_t;
    typedef logic [WORD_W-1:0]   word_t;

    // Packed so the struct maps bit-for-bit onto the 82-bit RAM line:
    // [81:66] tag, [65:2] words (word n at 16n+17:16n+2), [1] dirty, [0] valid.
    typedef struct packed {
        tag_t                   tag;
        logic [WORDS-1:0][WORD_W-1:0] words;
        logic                   dirty;
        logic                   valid;
    } line_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOOKUP  = 3'd1,
        ST_COMPARE = 3'd2,
        ST_WBACK   = 3'd3,
        ST_REFILL  = 3'd4,
        ST_FILL    = 3'd5
    } state_e;

    // Word address of one beat of a line burst.
    function automatic logic [ADDR_W-1:0] burst_addr(input tag_t tag, input index_t index,
                                                     input offset_t beat);
        return {tag, index, beat};
    endfunction

endpackage

// File: rtl/dcache_ctrl_if.sv
// Backing-memory word bus between the cache controller (master) and memory (slave).
interface dcache_ctrl_if;
    import dcache_pkg::*;

    logic              o_mem_req;
    logic              o_mem_we;
    logic [ADDR_W-1:0] o_mem_addr;
    word_t             o_mem_data;
    word_t             i_mem_data;
    logic              i_mem_ack;

    modport master (
        output o_mem_req, o_mem_we, o_mem_addr, o_mem_data,
        input  i_mem_data, i_mem_ack
    );

    modport slave (
        input  o_mem_req, o_mem_we, o_mem_addr, o_mem_data,
        output i_mem_data, i_mem_ack
    );

endinterface

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller.
// One 82-bit line per RAM entry, 4-word bursts to backing memory.
module dcache_ctrl
    import dcache_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst,
    // CPU side
    input  logic               i_req,
    input  logic               i_we,
    input  logic [ADDR_W-1:0]  i_addr,
    input  word_t              i_data,
    output word_t              o_data,
    output logic               o_ack,
    output logic               o_busy,
    // Backing memory side
    dcache_ctrl_if.master      mem,
    // Line RAM side (registered read)
    output index_t             o_ram_addr,
    output logic [LINE_W-1:0]  o_ram_data,
    output logic               o_ram_we,
    input  logic [LINE_W-1:0]  i_ram_data
);

    state_e            state_q, state_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    word_t             wdata_q, wdata_d;
    offset_t           cnt_q, cnt_d;
    line_t             buf_q, buf_d;
    word_t             data_q, data_d;

    tag_t    req_tag;
    index_t  req_index;
    offset_t req_offset;
    line_t   ram_line;
    logic    hit;
    logic    mem_ack;
    line_t   hit_line;
    line_t   fill_line;

    assign req_tag    = addr_q[22:7];
    assign req_index  = addr_q[6:2];
    assign req_offset = addr_q[1:0];
    assign ram_line   = line_t'(i_ram_data);
    assign hit        = ram_line.valid && (ram_line.tag == req_tag);
    // Acks outside a burst never reach the counter or the buffer.
    assign mem_ack    = mem.i_mem_ack && (state_q == ST_WBACK || state_q == ST_REFILL);

    assign o_busy     = (state_q != ST_IDLE);
    assign o_ram_addr = req_index;

    // State register.
    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
        if (i_rst) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Datapath registers: request latch, burst counter, line buffer, read-data hold.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            buf_q   <= '0;
            data_q  <= '0;
        end else begin
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            data_q  <= data_d;
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (i_req) state_d = ST_LOOKUP;
            ST_LOOKUP:  state_d = ST_COMPARE;
            ST_COMPARE: begin
                if (hit)                                  state_d = ST_IDLE;
                else if (ram_line.valid && ram_line.dirty) state_d = ST_WBACK;
                else                                      state_d = ST_REFILL;
            end
            ST_WBACK:   if (mem_ack && cnt_q == 2'd3) state_d = ST_REFILL;
            ST_REFILL:  if (mem_ack && cnt_q == 2'd3) state_d = ST_FILL;
            ST_FILL:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Datapath next values: latch on acceptance, capture victim on miss, count and fill beats.
    always_comb begin
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        data_d  = o_data;
        if (state_q == ST_IDLE && i_req) begin
            we_d    = i_we;
            addr_d  = i_addr;
            wdata_d = i_data;
        end
        if (state_q == ST_COMPARE && !hit) begin
            buf_d = ram_line;
        end
        if (mem_ack) begin
            cnt_d = cnt_q + 2'd1;
        end
        if (mem_ack && state_q == ST_REFILL) begin
            buf_d.words[cnt_q] = mem.i_mem_data;
        end
    end

    // Outputs: CPU ack/data, RAM write, memory burst signals.
    always_comb begin
        hit_line                    = ram_line;
        hit_line.words[req_offset]  = wdata_q;
        hit_line.dirty              = 1'b1;
        hit_line.valid              = 1'b1;

        fill_line.tag   = req_tag;
        fill_line.words = buf_q.words;
        if (we_q) fill_line.words[req_offset] = wdata_q;
        fill_line.dirty = we_q;
        fill_line.valid = 1'b1;

        o_ack          = 1'b0;
        o_data         = data_q;
        o_ram_we       = 1'b0;
        o_ram_data     = '0;
        mem.o_mem_req  = 1'b0;
        mem.o_mem_we   = 1'b0;
        mem.o_mem_addr = '0;
        mem.o_mem_data = '0;

        case (state_q)
            ST_COMPARE: begin
                if (hit) begin
                    o_ack  = 1'b1;
                    o_data = we_q ? wdata_q : ram_line.words[req_offset];
                    if (we_q) begin
                        o_ram_we   = 1'b1;
                        o_ram_data = hit_line;
                    end
                end
            end
            ST_WBACK: begin
                mem.o_mem_req  = 1'b1;
                mem.o_mem_we   = 1'b1;
                mem.o_mem_addr = burst_addr(buf_q.tag, req_index, cnt_q);
                mem.o_mem_data = buf_q.words[cnt_q];
            end
            ST_REFILL: begin
                mem.o_mem_req  = 1'b1;
                mem.o_mem_addr = burst_addr(req_tag, req_index, cnt_q);
            end
            ST_FILL: begin
                o_ram_we   = 1'b1;
                o_ram_data = fill_line;
                o_ack      = 1'b1;
                o_data     = fill_line.words[req_offset];
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Scoreboard bench for dcache_ctrl: expected CPU responses, RAM writes and memory
// beats are queued at issue time; monitors pop and compare when the DUT presents them.
module tb_dcache_ctrl;
    import dcache_pkg::*;

    logic               i_clk = 1'b0;
    logic               i_rst;
    logic               i_req, i_we;
    logic [ADDR_W-1:0]  i_addr;
    word_t              i_data, o_data;
    logic               o_ack, o_busy;
    index_t             o_ram_addr;
    logic [LINE_W-1:0]  o_ram_data, i_ram_data;
    logic               o_ram_we;
    logic               resp_ack, stray_ack;

    dcache_ctrl_if mem_bus();
    assign mem_bus.i_mem_ack = resp_ack | stray_ack;

    always #5 i_clk = ~i_clk;

    dcache_ctrl dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_req      (i_req),
        .i_we       (i_we),
        .i_addr     (i_addr),
        .i_data     (i_data),
        .o_data     (o_data),
        .o_ack      (o_ack),
        .o_busy     (o_busy),
        .mem        (mem_bus),
        .o_ram_addr (o_ram_addr),
        .o_ram_data (o_ram_data),
        .o_ram_we   (o_ram_we),
        .i_ram_data (i_ram_data)
    );

    typedef struct packed { logic [15:0] data; logic chk; } resp_t;
    typedef struct packed { logic we; logic [22:0] addr; logic [15:0] data; } memx_t;
    typedef struct packed { logic [4:0] addr; logic [81:0] line; } ramx_t;

    resp_t exp_resp[$];
    memx_t exp_mem[$];
    ramx_t exp_ram[$];

    int n_checks = 0;
    int n_fail   = 0;
    int mem_acks = 0;
    int ack_count = 0;
    bit mem_req_seen = 0;

    logic [15:0] backing [logic [22:0]];
    logic [81:0] ram [32];

    task automatic check(input string name, input logic [81:0] act, input logic [81:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s", name);
    endtask

    function automatic logic [15:0] mem_read(input logic [22:0] a);
        if (backing.exists(a)) return backing[a];
        return 16'h5000 | {4'h0, a[11:0]};
    endfunction

    function automatic logic [81:0] mk_line(input logic [15:0] tag, input logic [15:0] w3,
                                            input logic [15:0] w2, input logic [15:0] w1,
                                            input logic [15:0] w0, input logic dirty);
        return {tag, w3, w2, w1, w0, dirty, 1'b1};
    endfunction

    function automatic resp_t mk_resp(input logic [15:0] d, input logic c);
        resp_t r;
        r.data = d;
        r.chk  = c;
        return r;
    endfunction

    task automatic push_mem(input logic we, input logic [22:0] addr, input logic [15:0] data);
        memx_t m;
        m.we = we; m.addr = addr; m.data = data;
        exp_mem.push_back(m);
    endtask

    task automatic push_ram(input logic [4:0] addr, input logic [81:0] line);
        ramx_t r;
        r.addr = addr; r.line = line;
        exp_ram.push_back(r);
    endtask

    // Line RAM model: registered read, cleared by its own reset.
    always @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < 32; i++) ram[i] <= '0;
            i_ram_data <= '0;
        end else begin
            if (o_ram_we) ram[o_ram_addr] <= o_ram_data;
            i_ram_data <= ram[o_ram_addr];
        end
    end

    // Backing memory responder: acks every other cycle while requested, checks each beat.
    initial begin
        memx_t e;
        resp_ack = 1'b0;
        mem_bus.i_mem_data = '0;
        forever begin
            @(negedge i_clk);
            if (resp_ack) begin
                resp_ack = 1'b0;
            end else if (mem_bus.o_mem_req === 1'b1) begin
                mem_acks++;
                if (exp_mem.size() == 0) begin
                    flag("mem_unexpected_beat");
                end else begin
                    e = exp_mem.pop_front();
                    check("mem_we",   82'(mem_bus.o_mem_we),   82'(e.we));
                    check("mem_addr", 82'(mem_bus.o_mem_addr), 82'(e.addr));
                    if (e.we) check("mem_wdata", 82'(mem_bus.o_mem_data), 82'(e.data));
                end
                if (mem_bus.o_mem_we) backing[mem_bus.o_mem_addr] = mem_bus.o_mem_data;
                else                  mem_bus.i_mem_data = mem_read(mem_bus.o_mem_addr);
                resp_ack = 1'b1;
            end
        end
    end

    // CPU response and RAM write monitor.
    initial begin
        resp_t r;
        ramx_t w;
        forever begin
            @(negedge i_clk);
            if (mem_bus.o_mem_req === 1'b1) mem_req_seen = 1;
            if (o_ack === 1'b1) begin
                ack_count++;
                if (exp_resp.size() == 0) flag("cpu_unexpected_ack");
                else begin
                    r = exp_resp.pop_front();
                    if (r.chk) check("cpu_rdata", 82'(o_data), 82'(r.data));
                end
            end
            if (o_ram_we === 1'b1) begin
                if (exp_ram.size() == 0) flag("ram_unexpected_write");
                else begin
                    w = exp_ram.pop_front();
                    check("ram_addr", 82'(o_ram_addr), 82'(w.addr));
                    check("ram_line", o_ram_data, w.line);
                end
            end
        end
    end

    task automatic cpu_access(input logic we, input logic [22:0] addr, input logic [15:0] data,
                              input bit hold, output int lat);
        bit done;
        done = 0;
        lat  = 0;
        @(negedge i_clk);
        i_req = 1'b1; i_we = we; i_addr = addr; i_data = data;
        while (!done && lat < 200) begin
            @(posedge i_clk);
            lat++;
            @(negedge i_clk);
            if (!hold || o_ack === 1'b1) i_req = 1'b0;
            if (o_ack === 1'b1) done = 1;
        end
        i_req = 1'b0;
        if (!done) flag("cpu_ack_timeout");
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge i_clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int base;
        int acks_before;
        i_rst = 1'b1; i_req = 1'b0; i_we = 1'b0; i_addr = '0; i_data = '0; stray_ack = 1'b0;
        backing[23'h10] = 16'h00A0; backing[23'h11] = 16'h00A1;
        backing[23'h12] = 16'h00A2; backing[23'h13] = 16'h00A3;
        backing[23'h90] = 16'h00C0; backing[23'h91] = 16'h00C1;
        backing[23'h92] = 16'h00C2; backing[23'h93] = 16'h00C3;
        repeat (3) @(negedge i_clk);
        check("rst_busy",    82'(o_busy),          82'(0));
        check("rst_ack",     82'(o_ack),           82'(0));
        check("rst_mem_req", 82'(mem_bus.o_mem_req), 82'(0));
        check("rst_mem_we",  82'(mem_bus.o_mem_we),  82'(0));
        check("rst_ram_we",  82'(o_ram_we),        82'(0));
        check("rst_data",    82'(o_data),          82'(0));
        i_rst = 1'b0;
        idle(2);

        // Cold read miss: clean refill of line 4.
        for (int i = 0; i < 4; i++) push_mem(1'b0, 23'h10 + 23'(i), 16'h0);
        push_ram(5'd4, mk_line(16'h0, 16'h00A3, 16'h00A2, 16'h00A1, 16'h00A0, 1'b0));
        exp_resp.push_back(mk_resp(16'h00A2, 1'b1));
        cpu_access(1'b0, 23'h000012, 16'h0, 0, lat);
        idle(2);

        // Read hit: two-cycle latency, no memory traffic, o_data held afterwards.
        mem_req_seen = 0;
        exp_resp.push_back(mk_resp(16'h00A1, 1'b1));
        cpu_access(1'b0, 23'h000011, 16'h0, 0, lat);
        check("hit_latency", 82'(lat), 82'(2));
        @(negedge i_clk);
        check("rdata_hold", 82'(o_data), 82'(16'h00A1));
        check("hit_no_mem", 82'(mem_req_seen), 82'(0));
        idle(2);

        // Write hit: line updated in place and marked dirty.
        mem_req_seen = 0;
        push_ram(5'd4, mk_line(16'h0, 16'hBEEF, 16'h00A2, 16'h00A1, 16'h00A0, 1'b1));
        exp_resp.push_back(mk_resp(16'h0, 1'b0));
        cpu_access(1'b1, 23'h000013, 16'hBEEF, 0, lat);
        check("whit_latency", 82'(lat), 82'(2));
        check("whit_no_mem", 82'(mem_req_seen), 82'(0));
        idle(2);

        // Conflict miss on a dirty line: writeback then refill.
        push_mem(1'b1, 23'h10, 16'h00A0);
        push_mem(1'b1, 23'h11, 16'h00A1);
        push_mem(1'b1, 23'h12, 16'h00A2);
        push_mem(1'b1, 23'h13, 16'hBEEF);
        for (int i = 0; i < 4; i++) push_mem(1'b0, 23'h90 + 23'(i), 16'h0);
        push_ram(5'd4, mk_line(16'h1, 16'h00C3, 16'h00C2, 16'h00C1, 16'h00C0, 1'b0));
        exp_resp.push_back(mk_resp(16'h00C2, 1'b1));
        cpu_access(1'b0, 23'h000092, 16'h0, 0, lat);
        check("wback_stored", 82'(mem_read(23'h13)), 82'(16'hBEEF));
        idle(2);

        // i_req held high through a whole miss: exactly one acceptance.
        for (int i = 0; i < 4; i++) push_mem(1'b0, 23'hA0 + 23'(i), 16'h0);
        push_ram(5'd8, mk_line(16'h1, 16'h50A3, 16'h50A2, 16'h50A1, 16'h50A0, 1'b0));
        exp_resp.push_back(mk_resp(16'h50A0, 1'b1));
        cpu_access(1'b0, 23'h0000A0, 16'h0, 1, lat);
        acks_before = ack_count;
        idle(5);
        check("held_req_one_ack", 82'(ack_count), 82'(acks_before));
        check("held_req_idle", 82'(o_busy), 82'(0));

        // Stray memory ack while idle: no state change, counter untouched.
        stray_ack = 1'b1;
        @(negedge i_clk);
        stray_ack = 1'b0;
        @(negedge i_clk);
        check("stray_busy", 82'(o_busy), 82'(0));
        check("stray_mem_req", 82'(mem_bus.o_mem_req), 82'(0));
        for (int i = 0; i < 4; i++) push_mem(1'b0, 23'hC0 + 23'(i), 16'h0);
        push_ram(5'd16, mk_line(16'h1, 16'h50C3, 16'h50C2, 16'h50C1, 16'h50C0, 1'b0));
        exp_resp.push_back(mk_resp(16'h50C1, 1'b1));
        cpu_access(1'b0, 23'h0000C1, 16'h0, 0, lat);
        idle(2);

        // Reset in the middle of a refill after two beats.
        push_mem(1'b0, 23'hE0, 16'h0);
        push_mem(1'b0, 23'hE1, 16'h0);
        base = mem_acks;
        @(negedge i_clk);
        i_req = 1'b1; i_we = 1'b0; i_addr = 23'h0000E2;
        @(negedge i_clk);
        i_req = 1'b0;
        for (int i = 0; i < 100 && mem_acks < base + 2; i++) begin
            @(negedge i_clk);
            #1;
        end
        if (mem_acks < base + 2) flag("refill_beat_timeout");
        @(posedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        check("midrst_busy",    82'(o_busy),            82'(0));
        check("midrst_mem_req", 82'(mem_bus.o_mem_req), 82'(0));
        check("midrst_ram_we",  82'(o_ram_we),          82'(0));
        check("midrst_ack",     82'(o_ack),             82'(0));
        i_rst = 1'b0;
        idle(3);
        check("midrst_beats_left", 82'(exp_mem.size()), 82'(0));

        // Write miss after reset: refill with the new word merged, line dirty.
        for (int i = 0; i < 4; i++) push_mem(1'b0, 23'h34 + 23'(i), 16'h0);
        push_ram(5'd13, mk_line(16'h0, 16'h5037, 16'h5036, 16'h1234, 16'h5034, 1'b1));
        exp_resp.push_back(mk_resp(16'h1234, 1'b1));
        cpu_access(1'b1, 23'h000035, 16'h1234, 0, lat);
        idle(4);

        check("left_resp", 82'(exp_resp.size()), 82'(0));
        check("left_mem",  82'(exp_mem.size()),  82'(0));
        check("left_ram",  82'(exp_ram.size()),  82'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
